// File: rtl/fencei_flush_ctrl_if.sv
// Signal bundle between fencei_flush_ctrl and decode, store buffer, I-cache and fetch.
// The master modport is the environment side; the slave modport is the controller.
interface fencei_flush_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int IDX_W = 6
);
   logic             fencei_flush_pulse;
   logic [XLEN-1:0]  fencei_pc;
   logic             sb_empty;
   logic             ic_inv_valid;
   logic [IDX_W-1:0] ic_inv_idx;
   logic             ic_inv_ready;
   logic             fetch_redirect_valid;
   logic [XLEN-1:0]  fetch_redirect_pc;
   logic             stall_o;
   logic             busy;
   logic             fencei_done;
   logic             drain_err;

   modport master (
      output fencei_flush_pulse, fencei_pc, sb_empty, ic_inv_ready,
      input  ic_inv_valid, ic_inv_idx, fetch_redirect_valid, fetch_redirect_pc,
             stall_o, busy, fencei_done, drain_err
   );

   modport slave (
      input  fencei_flush_pulse, fencei_pc, sb_empty, ic_inv_ready,
      output ic_inv_valid, ic_inv_idx, fetch_redirect_valid, fetch_redirect_pc,
             stall_o, busy, fencei_done, drain_err
   );
endinterface

// File: rtl/fencei_flush_ctrl.sv
// FENCE.I sequencer: stall, drain the store buffer, invalidate every I-cache set,
// then redirect fetch to the instruction after the FENCE.I.
module fencei_flush_ctrl #(
   parameter int XLEN      = 32,
   parameter int IC_SETS   = 64,
   parameter int IDX_W     = $clog2(IC_SETS),
   parameter int DRAIN_TMO = 1024
) (
   input logic              clk,
   input logic              rst_n,
   fencei_flush_ctrl_if.slave bus
);
   localparam int TMO_W = $clog2(DRAIN_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(DRAIN_TMO);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TMO - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IC_SETS - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, INVAL, REDIRECT} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [XLEN-1:0]  pc_q;
   logic [TMO_W-1:0] tmo;
   logic             drain_err_q;
   logic             inv_valid_q;
   logic             redir_valid_q;
   logic [XLEN-1:0]  redir_pc_q;
   logic             done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         pc_q          <= '0;
         tmo           <= '0;
         drain_err_q   <= 1'b0;
         inv_valid_q   <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         done_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.fencei_flush_pulse) begin
                  pc_q        <= bus.fencei_pc;
                  idx         <= '0;
                  tmo         <= '0;
                  drain_err_q <= 1'b0;
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.sb_empty) begin
                  inv_valid_q <= 1'b1;
                  state       <= INVAL;
               end else begin
                  if (tmo != TMO_MAX) tmo <= tmo + TMO_W'(1);
                  // Flag goes up on the cycle tmo reaches DRAIN_TMO; the drain itself continues.
                  if (tmo >= TMO_LAST) drain_err_q <= 1'b1;
               end
            end
            INVAL: begin
               if (bus.ic_inv_ready) begin
                  if (idx == IDX_LAST) begin
                     inv_valid_q   <= 1'b0;
                     redir_valid_q <= 1'b1;
                     redir_pc_q    <= pc_q + XLEN'(4);
                     done_q        <= 1'b1;
                     state         <= REDIRECT;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            REDIRECT: begin
               redir_valid_q <= 1'b0;
               redir_pc_q    <= '0;
               done_q        <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stall is combinational so it also covers the pulse cycle itself.
   assign bus.stall_o              = bus.fencei_flush_pulse | (state != IDLE);
   assign bus.busy                 = (state != IDLE);
   assign bus.ic_inv_valid         = inv_valid_q;
   assign bus.ic_inv_idx           = idx;
   assign bus.fetch_redirect_valid = redir_valid_q;
   assign bus.fetch_redirect_pc    = redir_pc_q;
   assign bus.fencei_done          = done_q;
   assign bus.drain_err            = drain_err_q;
endmodule

// File: tb/tb_fencei_flush_ctrl.sv
// Scoreboard bench for fencei_flush_ctrl: two instances (long and short drain timeout)
// share one stimulus; expected handshakes/redirects are queued and checked by a monitor.
module tb_fencei_flush_ctrl;
   localparam int XLEN    = 32;
   localparam int IC_SETS = 4;
   localparam int IDX_W   = 2;
   localparam int TMO_A   = 1024;
   localparam int TMO_B   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pulse = 1'b0;
   logic [XLEN-1:0] fpc = '0;
   logic sb = 1'b1;
   logic rdy = 1'b1;
   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int          kind;   // 0 invalidate, 1 redirect
      logic [31:0] val;
      int          cyc;
   } ev_t;
   ev_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fencei_flush_ctrl_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus_a ();
   fencei_flush_ctrl_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus_b ();

   assign bus_a.fencei_flush_pulse = pulse;
   assign bus_a.fencei_pc          = fpc;
   assign bus_a.sb_empty           = sb;
   assign bus_a.ic_inv_ready       = rdy;
   assign bus_b.fencei_flush_pulse = pulse;
   assign bus_b.fencei_pc          = fpc;
   assign bus_b.sb_empty           = sb;
   assign bus_b.ic_inv_ready       = rdy;

   fencei_flush_ctrl #(.XLEN(XLEN), .IC_SETS(IC_SETS), .IDX_W(IDX_W), .DRAIN_TMO(TMO_A))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   fencei_flush_ctrl #(.XLEN(XLEN), .IC_SETS(IC_SETS), .IDX_W(IDX_W), .DRAIN_TMO(TMO_B))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops expected events whenever the DUT shows a handshake or redirect.
   logic hold_prev = 1'b0;
   logic [IDX_W-1:0] idx_prev = '0;
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pulse) chk("pulse_while_busy", {31'b0, bus_a.busy}, 32'd0);
            if (hold_prev && bus_a.ic_inv_valid)
               chk("idx_hold", {30'b0, bus_a.ic_inv_idx}, {30'b0, idx_prev});
            chk("done_eq_redirect", {31'b0, bus_a.fencei_done}, {31'b0, bus_a.fetch_redirect_valid});
            if (bus_a.ic_inv_valid && rdy) begin
               if (q.size() == 0) chk("unexpected_inval", 32'd1, 32'd0);
               else begin
                  e = q.pop_front();
                  chk("inval_kind", 32'd0, e.kind);
                  chk("inval_idx", {30'b0, bus_a.ic_inv_idx}, e.val);
                  chk("inval_cycle", cyc, e.cyc);
               end
            end
            if (bus_a.fetch_redirect_valid) begin
               if (q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
               else begin
                  e = q.pop_front();
                  chk("redirect_kind", 32'd1, e.kind);
                  chk("redirect_pc", bus_a.fetch_redirect_pc, e.val);
                  chk("redirect_cycle", cyc, e.cyc);
               end
            end
            hold_prev = bus_a.ic_inv_valid && !rdy;
            idx_prev  = bus_a.ic_inv_idx;
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_inv_valid"}, {31'b0, bus_a.ic_inv_valid}, 32'd0);
      chk({tag, "_inv_idx"}, {30'b0, bus_a.ic_inv_idx}, 32'd0);
      chk({tag, "_redir_valid"}, {31'b0, bus_a.fetch_redirect_valid}, 32'd0);
      chk({tag, "_redir_pc"}, bus_a.fetch_redirect_pc, 32'd0);
      chk({tag, "_stall"}, {31'b0, bus_a.stall_o}, 32'd0);
      chk({tag, "_busy"}, {31'b0, bus_a.busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, bus_a.fencei_done}, 32'd0);
      chk({tag, "_drain_err_a"}, {31'b0, bus_a.drain_err}, 32'd0);
      chk({tag, "_drain_err_b"}, {31'b0, bus_b.drain_err}, 32'd0);
   endtask

   // One FENCE.I sequence. drain_low: cycles sb_empty stays low after the pulse;
   // toggle: ready pattern 1,0,0,1 from the first INVAL cycle; abort_idx >= 0 resets there.
   task automatic fence(input logic [31:0] pc, input int drain_low, input bit toggle,
                        input int abort_idx);
      int p, s, r, lows;
      int offs[4];
      logic [3:0] pat;
      pat = 4'b1001;
      tick();
      p = cyc;
      s = p + 2 + drain_low;
      for (int i = 0; i < 4; i++) offs[i] = toggle ? ((i == 0) ? 0 : (i == 1) ? 3 : (i == 2) ? 4 : 7) : i;
      for (int i = 0; i < 4; i++)
         if (abort_idx < 0 || i < abort_idx) q.push_back('{0, 32'(i), s + offs[i]});
      r = s + offs[3] + 1;
      if (abort_idx < 0) q.push_back('{1, pc + 32'd4, r});
      pulse = 1'b1;
      fpc   = pc;
      sb    = (drain_low == 0);
      rdy   = 1'b1;
      for (int c = p; c <= r + 1; c++) begin
         if (c != p) begin
            tick();
            pulse = 1'b0;
            sb    = (cyc >= p + 1 + drain_low);
            rdy   = (toggle && cyc >= s) ? pat[(cyc - s) % 4] : 1'b1;
         end
         if (abort_idx >= 0 && cyc == s + abort_idx) begin
            #1 rst_n = 1'b0;
            #1 chk_zero_outputs("abort");
            tick();
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
         chk("stall", {31'b0, bus_a.stall_o}, {31'b0, (cyc <= r)});
         chk("busy", {31'b0, bus_a.busy}, {31'b0, (cyc > p && cyc <= r)});
         if (cyc > p) begin
            lows = (cyc - p - 1 < drain_low) ? cyc - p - 1 : drain_low;
            chk("drain_err_a", {31'b0, bus_a.drain_err}, {31'b0, (lows >= TMO_A)});
            chk("drain_err_b", {31'b0, bus_b.drain_err}, {31'b0, (lows >= TMO_B)});
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero_outputs("reset");
      tick();
      rst_n = 1'b1;
      fence(32'h0000_1000, 0, 1'b0, -1);
      repeat (2) tick();
      fence(32'h0000_2000, 10, 1'b0, -1);
      repeat (2) tick();
      fence(32'h0000_3000, 20, 1'b0, -1);
      tick();
      chk("drain_err_b_sticky", {31'b0, bus_b.drain_err}, 32'd1);
      fence(32'h0000_4000, 0, 1'b1, -1);
      repeat (2) tick();
      fence(32'hFFFF_FFFC, 0, 1'b0, -1);
      repeat (2) tick();
      fence(32'h0000_5000, 0, 1'b0, 2);
      repeat (3) tick();
      chk("abort_no_pending", q.size(), 32'd0);
      fence(32'h0000_6000, 0, 1'b0, -1);
      repeat (3) tick();
      chk("queue_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
